coin_acceptor_frontend: RTL and testbench
=========================================

# coin_acceptor_frontend

Upstream front end of the beverage vending machine. It converts the two raw, bouncy, asynchronous coin-slot sensors into the clean single-cycle `half_dollar` / `one_dollar` pulses consumed by the vending state machine. Detected coins are queued so that at most one coin pulse is presented per cycle, the two pulses are never asserted together, and coins arriving while acceptance is disabled or the queue is full are rejected back to the customer.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a sensor level change is accepted; legal range ≥2.
- `QUEUE_DEPTH`, default 4: coin queue entries; power of two, ≥2.
- `PULSE_GAP`, default 1: idle cycles forced between successive coin pulses; ≥0.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sense_half` in 1: raw half-dollar slot sensor, asynchronous, high while a coin passes.
- `sense_one` in 1: raw one-dollar slot sensor, asynchronous.
- `accept_en` in 1: synchronous; 1 means coins are accepted, 0 means every newly detected coin is rejected.
- `half_dollar` out 1: one-cycle pulse, one half dollar credited downstream.
- `one_dollar` out 1: one-cycle pulse, one dollar credited downstream.
- `reject_half` out 1: one-cycle pulse, drives the return gate for a half-dollar coin.
- `reject_one` out 1: one-cycle pulse, drives the return gate for a one-dollar coin.
- `queue_count` out $clog2(QUEUE_DEPTH)+1: number of coins queued but not yet pulsed.

## Operation
- Each sensor passes through a 2-flop synchronizer, then a debouncer. The debouncer holds a stable level and a counter. The counter resets whenever the synchronized input equals the stable level. When the counter reaches DEBOUNCE_CYCLES, the stable level takes the new value.
- A 0→1 transition of a stable level is a coin event, one cycle wide. Falling edges produce nothing.
- Event handling, evaluated in the same cycle:
  - If `accept_en`=0, the coin is rejected.
  - Otherwise, if the queue has room, the coin is pushed.
  - Otherwise the coin is rejected.
- Simultaneous half and one events:
  - The half coin is handled first, then the one coin.
  - With two free entries, both are pushed, half ahead of one.
  - With one free entry, half is pushed and one is rejected.
  - With none free, both are rejected.
- Queue entries are 1 bit: 0 = half, 1 = one. The queue is a circular buffer with wrap-around read and write pointers.
- Output stage:
  - A pop occurs when the queue is non-empty and the gap counter is 0. The popped entry asserts exactly one of `half_dollar` / `one_dollar` for one cycle.
  - The gap counter then loads PULSE_GAP and decrements to 0.
- Push and pop may occur in the same cycle. `queue_count` changes by (pushes − pops). Fullness is evaluated before the same-cycle pop, so a full queue rejects even while popping.
- `accept_en` does not affect coins already queued; they still drain.
- Reset (asynchronous, any time, including mid-debounce or with a non-empty queue): all four outputs 0, `queue_count` 0, queue empty, pointers 0, stable levels 0, debounce counters 0, gap counter 0, synchronizers 0. Queued coins are discarded.

## Timing
- Reset values: `half_dollar`=0, `one_dollar`=0, `reject_half`=0, `reject_one`=0, `queue_count`=0.
- All outputs are registered and have no combinational path from inputs.
- Latency with the queue empty and gap 0: a sensor high at rising edge N, held stable, gives the coin pulse high in the cycle after edge N+DEBOUNCE_CYCLES+3.
- A reject pulse asserts one cycle earlier than the coin pulse would have.
- `queue_count` updates at the push edge, one cycle before the first pulse.
- Sustained throughput is one coin pulse per PULSE_GAP+1 cycles.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no event.

## Structure
- Shared package `vend_pkg`:
  - coin-type constants `COIN_HALF`=1'b0 and `COIN_ONE`=1'b1;
  - default parameter constants, reused by the vending FSM and the change/dispense blocks.
- Sub-module `coin_debounce`, holding the synchronizer, counter, stable level and rising-edge event. It is instantiated twice, once per sensor.
- The queue and output pacing live in the top module.

## Test plan
- Single coin: `sense_half` high 40 cycles, DEBOUNCE_CYCLES=16, `accept_en`=1 → exactly one `half_dollar` pulse, high in the cycle after edge 19. No reject; `queue_count` goes 0→1→0.
- Bounce: `sense_one` toggling every 3 cycles for 30 cycles, then high 30 cycles → exactly one `one_dollar` pulse, and nothing from the toggling phase.
- Simultaneous coins: both sensors rise in the same cycle, queue empty, PULSE_GAP=1 → `half_dollar` pulse, one idle cycle, then `one_dollar` pulse. The two are never high together.
- Overflow: 5 one-dollar events with pops stalled by gap PULSE_GAP=20, QUEUE_DEPTH=4 → 4 queued, the 5th gives `reject_one`, and exactly 4 `one_dollar` pulses drain.
- Disabled: `accept_en`=0 with a half coin → `reject_half` pulse, no `half_dollar`, `queue_count` stays 0.
- Reset mid-operation: `rst_n` low with 3 coins queued → all outputs 0 immediately. After release, no pulses until a new coin event.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: coin encodings and default block parameters.
package vend_pkg;
    localparam logic COIN_HALF = 1'b0;
    localparam logic COIN_ONE  = 1'b1;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_QUEUE_DEPTH     = 4;
    localparam int DEF_PULSE_GAP       = 1;
endpackage

// File: rtl/coin_acceptor_frontend_if.sv
// Sensor inputs and credit/reject outputs of the coin acceptor front end.
interface coin_acceptor_frontend_if #(
    parameter int QUEUE_DEPTH = 4
);
    logic                           sense_half;
    logic                           sense_one;
    logic                           accept_en;
    logic                           half_dollar;
    logic                           one_dollar;
    logic                           reject_half;
    logic                           reject_one;
    logic [$clog2(QUEUE_DEPTH):0]   queue_count;

    modport master (
        output sense_half, sense_one, accept_en,
        input  half_dollar, one_dollar, reject_half, reject_one, queue_count
    );

    modport slave (
        input  sense_half, sense_one, accept_en,
        output half_dollar, one_dollar, reject_half, reject_one, queue_count
    );
endinterface

// File: rtl/coin_debounce.sv
// Per-sensor synchronizer + debouncer; emits a one-cycle event on each accepted 0->1 level change.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sense,
    output logic coin_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            stable   <= 1'b0;
            cnt      <= '0;
            coin_evt <= 1'b0;
        end else begin
            sync     <= {sync[0], sense};
            coin_evt <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // This sample is the DEBOUNCE_CYCLES-th differing one: commit the new level.
                stable   <= sync[1];
                cnt      <= '0;
                coin_evt <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/coin_acceptor_frontend.sv
// Coin acceptor front end: debounces both slot sensors, queues accepted coins and paces
// them out as single-cycle credit pulses; refused coins get a reject pulse.
module coin_acceptor_frontend
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int QUEUE_DEPTH     = DEF_QUEUE_DEPTH,
    parameter int PULSE_GAP       = DEF_PULSE_GAP
) (
    input  logic                      clk,
    input  logic                      rst_n,
    coin_acceptor_frontend_if.slave   bus
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (PULSE_GAP > 0) ? $clog2(PULSE_GAP + 1) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    logic [1:0]             sense, evt;
    logic [QUEUE_DEPTH-1:0] q_mem;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [GW-1:0]          gap;
    logic                   push_half, push_one, pop;
    logic                   half_q, one_q, rej_half_q, rej_one_q;

    assign sense[COIN_HALF] = bus.sense_half;
    assign sense[COIN_ONE]  = bus.sense_one;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .sense    (sense),
        .coin_evt (evt)
    );

    // Half coin claims a free slot first; fullness ignores any same-cycle pop.
    always_comb begin
        push_half = evt[COIN_HALF] && bus.accept_en && (count != DEPTH_C);
        push_one  = evt[COIN_ONE] && bus.accept_en &&
                    ((count + CW'(push_half)) < DEPTH_C);
        pop       = (count != '0) && (gap == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_mem      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            gap        <= '0;
            half_q     <= 1'b0;
            one_q      <= 1'b0;
            rej_half_q <= 1'b0;
            rej_one_q  <= 1'b0;
        end else begin
            if (push_half) q_mem[wr_ptr] <= COIN_HALF;
            if (push_one)  q_mem[wr_ptr + AW'(push_half)] <= COIN_ONE;
            wr_ptr <= wr_ptr + AW'(push_half) + AW'(push_one);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push_half) + CW'(push_one) - CW'(pop);

            if (pop)              gap <= GW'(PULSE_GAP);
            else if (gap != '0)   gap <= gap - 1'b1;

            half_q     <= pop && (q_mem[rd_ptr] == COIN_HALF);
            one_q      <= pop && (q_mem[rd_ptr] == COIN_ONE);
            rej_half_q <= evt[COIN_HALF] && !push_half;
            rej_one_q  <= evt[COIN_ONE] && !push_one;
        end
    end

    assign bus.half_dollar = half_q;
    assign bus.one_dollar  = one_q;
    assign bus.reject_half = rej_half_q;
    assign bus.reject_one  = rej_one_q;
    assign bus.queue_count = count;
endmodule

// File: tb/tb_coin_acceptor_frontend.sv
// Directed bench: dut_a (debounce 16, gap 1) for timing/bounce/simultaneous/disable,
// dut_b (debounce 2, gap 20) for overflow and reset with a loaded queue.
module tb_coin_acceptor_frontend;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coin_acceptor_frontend_if #(.QUEUE_DEPTH(4)) if_a ();
    coin_acceptor_frontend_if #(.QUEUE_DEPTH(4)) if_b ();

    coin_acceptor_frontend #(.DEBOUNCE_CYCLES(16), .QUEUE_DEPTH(4), .PULSE_GAP(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    coin_acceptor_frontend #(.DEBOUNCE_CYCLES(2), .QUEUE_DEPTH(4), .PULSE_GAP(20)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    int n_chk = 0;
    int n_fail = 0;

    // Pulse tallies, sampled mid-cycle; tests look at deltas.
    int a_half = 0, a_one = 0, a_rh = 0, a_ro = 0, b_half = 0, b_one = 0, b_rh = 0, b_ro = 0;
    int a_both = 0, b_both = 0;
    always @(negedge clk) begin
        a_half <= a_half + int'(if_a.half_dollar);
        a_one  <= a_one  + int'(if_a.one_dollar);
        a_rh   <= a_rh   + int'(if_a.reject_half);
        a_ro   <= a_ro   + int'(if_a.reject_one);
        b_half <= b_half + int'(if_b.half_dollar);
        b_one  <= b_one  + int'(if_b.one_dollar);
        b_rh   <= b_rh   + int'(if_b.reject_half);
        b_ro   <= b_ro   + int'(if_b.reject_one);
        a_both <= a_both + int'(if_a.half_dollar & if_a.one_dollar);
        b_both <= b_both + int'(if_b.half_dollar & if_b.one_dollar);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        if_a.sense_half = 0; if_a.sense_one = 0; if_a.accept_en = 1;
        if_b.sense_half = 0; if_b.sense_one = 0; if_b.accept_en = 1;
        #2;
        n_chk++;
        if ({if_a.half_dollar, if_a.one_dollar, if_a.reject_half, if_a.reject_one} !== 4'b0) begin
            n_fail++; $display("FAIL reset_a_outputs: got %b expected 0000",
                {if_a.half_dollar, if_a.one_dollar, if_a.reject_half, if_a.reject_one});
        end
        n_chk++;
        if (if_a.queue_count !== 3'd0) begin
            n_fail++; $display("FAIL reset_a_count: got %0d expected 0", if_a.queue_count);
        end
        n_chk++;
        if ({if_b.half_dollar, if_b.one_dollar, if_b.reject_half, if_b.reject_one, if_b.queue_count} !== 7'b0) begin
            n_fail++; $display("FAIL reset_b_state: got %b expected 0",
                {if_b.half_dollar, if_b.one_dollar, if_b.reject_half, if_b.reject_one, if_b.queue_count});
        end
        idle(3);
        rst_n = 1;
        idle(5);
    endtask

    task automatic test_single_coin;
        int h0, o0, r0, first, q17, q18, q19;
        h0 = a_half; o0 = a_one; r0 = a_rh + a_ro; first = -1; q17 = -1; q18 = -1; q19 = -1;
        if_a.sense_half = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (if_a.half_dollar && first < 0) first = i;
            if (i == 17) q17 = int'(if_a.queue_count);
            if (i == 18) q18 = int'(if_a.queue_count);
            if (i == 19) q19 = int'(if_a.queue_count);
        end
        if_a.sense_half = 0;
        idle(40);
        n_chk++; if (first != 19) begin n_fail++; $display("FAIL single_latency: got edge %0d expected 19", first); end
        n_chk++; if (q17 != 0) begin n_fail++; $display("FAIL single_count_pre: got %0d expected 0", q17); end
        n_chk++; if (q18 != 1) begin n_fail++; $display("FAIL single_count_push: got %0d expected 1", q18); end
        n_chk++; if (q19 != 0) begin n_fail++; $display("FAIL single_count_pop: got %0d expected 0", q19); end
        n_chk++; if (a_half - h0 != 1) begin n_fail++; $display("FAIL single_half_pulses: got %0d expected 1", a_half - h0); end
        n_chk++; if (a_one - o0 + a_rh + a_ro - r0 != 0) begin
            n_fail++; $display("FAIL single_spurious: got %0d expected 0", a_one - o0 + a_rh + a_ro - r0); end
    endtask

    task automatic test_bounce;
        int o0, h0, mid;
        o0 = a_one; h0 = a_half;
        for (int k = 0; k < 5; k++) begin
            if_a.sense_one = 1; idle(3);
            if_a.sense_one = 0; idle(3);
        end
        if_a.sense_one = 1;
        idle(10);
        mid = a_one - o0;
        idle(20);
        if_a.sense_one = 0;
        idle(40);
        n_chk++; if (mid != 0) begin n_fail++; $display("FAIL bounce_glitch_pulse: got %0d expected 0", mid); end
        n_chk++; if (a_one - o0 != 1) begin n_fail++; $display("FAIL bounce_one_pulses: got %0d expected 1", a_one - o0); end
        n_chk++; if (a_half - h0 != 0) begin n_fail++; $display("FAIL bounce_half_pulses: got %0d expected 0", a_half - h0); end
    endtask

    task automatic test_simultaneous;
        int fh, fo, idle20, h0, o0, bo0;
        h0 = a_half; o0 = a_one; bo0 = a_both; fh = -1; fo = -1; idle20 = -1;
        if_a.sense_half = 1; if_a.sense_one = 1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); @(negedge clk);
            if (if_a.half_dollar && fh < 0) fh = i;
            if (if_a.one_dollar && fo < 0) fo = i;
            if (i == 20) idle20 = int'(if_a.half_dollar) + int'(if_a.one_dollar);
        end
        if_a.sense_half = 0; if_a.sense_one = 0;
        idle(40);
        n_chk++; if (fh != 19) begin n_fail++; $display("FAIL simul_half_edge: got %0d expected 19", fh); end
        n_chk++; if (idle20 != 0) begin n_fail++; $display("FAIL simul_gap_cycle: got %0d expected 0", idle20); end
        n_chk++; if (fo != 21) begin n_fail++; $display("FAIL simul_one_edge: got %0d expected 21", fo); end
        n_chk++; if (a_both - bo0 != 0) begin n_fail++; $display("FAIL simul_overlap: got %0d expected 0", a_both - bo0); end
        n_chk++; if ((a_half - h0 != 1) || (a_one - o0 != 1)) begin
            n_fail++; $display("FAIL simul_counts: got half %0d one %0d expected 1 1", a_half - h0, a_one - o0); end
    endtask

    task automatic test_disabled;
        int h0, rh0, first, qmax;
        h0 = a_half; rh0 = a_rh; first = -1; qmax = 0;
        if_a.accept_en = 0;
        if_a.sense_half = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (if_a.reject_half && first < 0) first = i;
            if (int'(if_a.queue_count) > qmax) qmax = int'(if_a.queue_count);
        end
        if_a.sense_half = 0;
        idle(40);
        if_a.accept_en = 1;
        n_chk++; if (first != 18) begin n_fail++; $display("FAIL disabled_reject_edge: got %0d expected 18", first); end
        n_chk++; if (a_rh - rh0 != 1) begin n_fail++; $display("FAIL disabled_reject_count: got %0d expected 1", a_rh - rh0); end
        n_chk++; if (a_half - h0 != 0) begin n_fail++; $display("FAIL disabled_half: got %0d expected 0", a_half - h0); end
        n_chk++; if (qmax != 0) begin n_fail++; $display("FAIL disabled_count: got %0d expected 0", qmax); end
    endtask

    // Half coin first so its pulse opens a 20-cycle gap; then n one-dollar coins every 4 cycles.
    task automatic prime_and_ones(input int n, output int qmax);
        qmax = 0;
        if_b.sense_half = 1;
        idle(2);
        if_b.sense_half = 0;
        for (int k = 0; k < n; k++) begin
            if_b.sense_one = 1;
            repeat (2) begin @(negedge clk); if (int'(if_b.queue_count) > qmax) qmax = int'(if_b.queue_count); end
            if_b.sense_one = 0;
            repeat (2) begin @(negedge clk); if (int'(if_b.queue_count) > qmax) qmax = int'(if_b.queue_count); end
        end
    endtask

    task automatic test_overflow;
        int h0, o0, rh0, ro0, bo0, qmax;
        h0 = b_half; o0 = b_one; rh0 = b_rh; ro0 = b_ro; bo0 = b_both;
        prime_and_ones(5, qmax);
        idle(110);
        n_chk++; if (qmax != 4) begin n_fail++; $display("FAIL overflow_peak_count: got %0d expected 4", qmax); end
        n_chk++; if (b_ro - ro0 != 1) begin n_fail++; $display("FAIL overflow_reject_one: got %0d expected 1", b_ro - ro0); end
        n_chk++; if (b_one - o0 != 4) begin n_fail++; $display("FAIL overflow_one_pulses: got %0d expected 4", b_one - o0); end
        n_chk++; if ((b_half - h0 != 1) || (b_rh - rh0 != 0)) begin
            n_fail++; $display("FAIL overflow_half: got pulses %0d rejects %0d expected 1 0", b_half - h0, b_rh - rh0); end
        n_chk++; if (if_b.queue_count !== 3'd0) begin n_fail++; $display("FAIL overflow_drained: got %0d expected 0", if_b.queue_count); end
        n_chk++; if (b_both - bo0 != 0) begin n_fail++; $display("FAIL overflow_overlap: got %0d expected 0", b_both - bo0); end
    endtask

    task automatic test_reset_mid;
        int qmax, o0, h0, r0;
        prime_and_ones(3, qmax);
        idle(3);
        n_chk++; if (if_b.queue_count !== 3'd3) begin n_fail++; $display("FAIL rstmid_loaded: got %0d expected 3", if_b.queue_count); end
        #2 rst_n = 0;
        #1;
        n_chk++;
        if ({if_b.half_dollar, if_b.one_dollar, if_b.reject_half, if_b.reject_one, if_b.queue_count} !== 7'b0) begin
            n_fail++; $display("FAIL rstmid_async: got %b expected 0",
                {if_b.half_dollar, if_b.one_dollar, if_b.reject_half, if_b.reject_one, if_b.queue_count});
        end
        idle(3);
        rst_n = 1;
        o0 = b_one; h0 = b_half; r0 = b_rh + b_ro;
        idle(60);
        n_chk++; if ((b_one - o0) + (b_half - h0) + (b_rh + b_ro - r0) != 0) begin
            n_fail++; $display("FAIL rstmid_no_pulses: got %0d expected 0", (b_one - o0) + (b_half - h0) + (b_rh + b_ro - r0)); end
        n_chk++; if (if_b.queue_count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", if_b.queue_count); end
        if_b.sense_one = 1; idle(4); if_b.sense_one = 0;
        idle(20);
        n_chk++; if (b_one - o0 != 1) begin n_fail++; $display("FAIL rstmid_new_coin: got %0d expected 1", b_one - o0); end
    endtask

    initial begin
        test_reset();
        test_single_coin();
        test_bounce();
        test_simultaneous();
        test_disabled();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
